// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and FSM state type for the 3x3 window generator
package cnn_pkg;

    localparam int KERNEL_DIM    = 3;
    localparam int KERNEL_SIZE   = KERNEL_DIM * KERNEL_DIM;

    // Window element indices of the right-hand column (i = 3*r + c)
    localparam int WIN_TOP_RIGHT = KERNEL_DIM - 1;
    localparam int WIN_MID_RIGHT = 2 * KERNEL_DIM - 1;
    localparam int WIN_NEWEST    = KERNEL_SIZE - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-row pixel store, combinational read, synchronous write
module line_buffer #(
    parameter int DATA_RES = 8,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DATA_RES-1:0] wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [DATA_RES-1:0] rdata_o
);

    logic [DATA_RES-1:0] mem_q [DEPTH];
    logic [DATA_RES-1:0] mem_d [DEPTH];

    // Read sees the old contents when the same address is written this cycle
    assign rdata_o = mem_q[raddr_i];

    // Next-state of the row store: one entry replaced on write
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Row storage is never cleared; stale entries are masked by the window logic
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 3x3 window generator with stall shared with the MAC
module conv_window_gen #(
    parameter int DATA_RES         = 8,
    parameter int KERNEL_SIZE      = 9,
    parameter int MAX_LINE_WIDTH   = 32,
    parameter int MAX_FRAME_HEIGHT = 32
) (
    input  logic                                  clk_i,
    input  logic                                  resetn_i,
    input  logic                                  DMA_not_ready,
    input  logic [$clog2(MAX_LINE_WIDTH+1)-1:0]   line_width_i,
    input  logic [$clog2(MAX_FRAME_HEIGHT+1)-1:0] frame_height_i,
    input  logic                                  start_i,
    input  logic [DATA_RES-1:0]                   pixel_i,
    input  logic                                  pixel_valid_i,
    output logic                                  pixel_ready_o,
    output logic [DATA_RES*KERNEL_SIZE-1:0]       pixel_grid_o,
    output logic                                  data_valid_o,
    output logic                                  busy_o,
    output logic                                  frame_done_o
);

    import cnn_pkg::*;

    localparam int LW_W = $clog2(MAX_LINE_WIDTH + 1);
    localparam int FH_W = $clog2(MAX_FRAME_HEIGHT + 1);
    localparam int AW   = $clog2(MAX_LINE_WIDTH);
    localparam int GW   = DATA_RES * KERNEL_SIZE;

    win_state_t          state_q, state_d;
    logic [LW_W-1:0]     col_q, col_d;
    logic [LW_W-1:0]     width_q, width_d;
    logic [FH_W-1:0]     row_q, row_d;
    logic [FH_W-1:0]     height_q, height_d;
    logic [GW-1:0]       grid_q, grid_d;
    logic                valid_q, valid_d;

    logic                accept;
    logic                geom_ok;
    logic                col_last;
    logic                row_last;
    logic [AW-1:0]       lb_addr;
    logic [DATA_RES-1:0] top_px;
    logic [DATA_RES-1:0] mid_px;

    assign pixel_ready_o = ((state_q == S_PRIME) || (state_q == S_STREAM)) && !DMA_not_ready;
    assign accept        = pixel_valid_i && pixel_ready_o;
    assign busy_o        = (state_q != S_IDLE);
    assign frame_done_o  = (state_q == S_DONE);
    assign pixel_grid_o  = grid_q;
    assign data_valid_o  = valid_q;

    assign geom_ok  = (line_width_i   >= LW_W'(3)) && (line_width_i   <= LW_W'(MAX_LINE_WIDTH)) &&
                      (frame_height_i >= FH_W'(3)) && (frame_height_i <= FH_W'(MAX_FRAME_HEIGHT));
    assign col_last = (col_q == width_q - LW_W'(1));
    assign row_last = (row_q == height_q - FH_W'(1));
    assign lb_addr  = col_q[AW-1:0];

    // lb0 holds the previous row, lb1 the row before it; lb1 is fed from lb0's old entry
    line_buffer #(.DATA_RES(DATA_RES), .DEPTH(MAX_LINE_WIDTH), .AW(AW)) u_lb0 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .waddr_i (lb_addr),
        .wdata_i (pixel_i),
        .raddr_i (lb_addr),
        .rdata_o (mid_px)
    );

    line_buffer #(.DATA_RES(DATA_RES), .DEPTH(MAX_LINE_WIDTH), .AW(AW)) u_lb1 (
        .clk_i   (clk_i),
        .we_i    (accept),
        .waddr_i (lb_addr),
        .wdata_i (mid_px),
        .raddr_i (lb_addr),
        .rdata_o (top_px)
    );

    // Next-state: FSM, raster counters and window shift; everything holds under stall except DONE
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        width_d  = width_q;
        height_d = height_q;
        grid_d   = grid_q;
        valid_d  = valid_q;

        if (state_q == S_DONE) begin
            state_d = S_IDLE;
            if (!DMA_not_ready) begin
                valid_d = 1'b0;
            end
        end else if (!DMA_not_ready) begin
            valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && geom_ok) begin
                        width_d  = line_width_i;
                        height_d = frame_height_i;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = S_PRIME;
                    end
                end
                S_PRIME, S_STREAM: begin
                    if (accept) begin
                        for (int r = 0; r < KERNEL_DIM; r++) begin
                            for (int c = 0; c < KERNEL_DIM - 1; c++) begin
                                grid_d[(r*KERNEL_DIM + c)*DATA_RES +: DATA_RES] =
                                    grid_q[(r*KERNEL_DIM + c + 1)*DATA_RES +: DATA_RES];
                            end
                        end
                        grid_d[WIN_TOP_RIGHT*DATA_RES +: DATA_RES] = top_px;
                        grid_d[WIN_MID_RIGHT*DATA_RES +: DATA_RES] = mid_px;
                        grid_d[WIN_NEWEST*DATA_RES    +: DATA_RES] = pixel_i;

                        valid_d = (state_q == S_STREAM) && (col_q >= LW_W'(2));

                        if (col_last) begin
                            col_d = '0;
                            if (row_last) begin
                                state_d = S_DONE;
                            end else begin
                                row_d = row_q + FH_W'(1);
                                if ((state_q == S_PRIME) && (row_q == FH_W'(1))) begin
                                    state_d = S_STREAM;
                                end
                            end
                        end else begin
                            col_d = col_q + LW_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous clear; partial frames are discarded on reset
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            grid_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
            grid_q   <= grid_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - randomized self-checking bench for conv_window_gen
module tb_conv_window_gen;

    localparam int DR = 8;
    localparam int GW = DR * 9;

    logic          clk_i;
    logic          resetn_i;
    logic          DMA_not_ready;
    logic [5:0]    line_width_i;
    logic [5:0]    frame_height_i;
    logic          start_i;
    logic [DR-1:0] pixel_i;
    logic          pixel_valid_i;
    logic          pixel_ready_o;
    logic [GW-1:0] pixel_grid_o;
    logic          data_valid_o;
    logic          busy_o;
    logic          frame_done_o;

    int checks;
    int failures;

    logic [DR-1:0] img [32][32];
    logic [GW-1:0] got[$];
    logic [GW-1:0] exp_q[$];

    conv_window_gen dut (
        .clk_i          (clk_i),
        .resetn_i       (resetn_i),
        .DMA_not_ready  (DMA_not_ready),
        .line_width_i   (line_width_i),
        .frame_height_i (frame_height_i),
        .start_i        (start_i),
        .pixel_i        (pixel_i),
        .pixel_valid_i  (pixel_valid_i),
        .pixel_ready_o  (pixel_ready_o),
        .pixel_grid_o   (pixel_grid_o),
        .data_valid_o   (data_valid_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // mode 0: no stall, 1: random stall and valid gaps, 2: one 3-cycle stall on first window
    task automatic run_frame(input int w, input int h, input int mode, input bit start_in_done);
        int idx, cyc, last_acc, done_cyc, done_cnt, stall_left, chk_left, n;
        bit stalled_once;
        logic [GW-1:0] held;
        logic [GW-1:0] win;
        got.delete();
        exp_q.delete();
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                for (int k = 0; k < 9; k++) begin
                    win[k*DR +: DR] = img[r - 2 + k/3][c - 2 + k%3];
                end
                exp_q.push_back(win);
            end
        end
        @(negedge clk_i);
        line_width_i   = 6'(w);
        frame_height_i = 6'(h);
        start_i        = 1'b1;
        DMA_not_ready  = 1'b0;
        pixel_valid_i  = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        idx = 0; cyc = 0; last_acc = -1; done_cyc = -1; done_cnt = 0;
        stall_left = 0; chk_left = 0; stalled_once = 0; held = '0;
        while (idx < w*h && cyc < 4000) begin
            if (chk_left > 0) begin
                checks++;
                if (pixel_grid_o !== held || data_valid_o !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold: grid=%h valid=%b required grid=%h valid=1", pixel_grid_o, data_valid_o, held);
                end
                chk_left--;
            end
            if (frame_done_o) done_cnt++;
            if (mode == 2 && !stalled_once && data_valid_o) begin
                stalled_once = 1; stall_left = 3; chk_left = 3; held = pixel_grid_o;
            end
            if (stall_left > 0) begin
                DMA_not_ready = 1'b1;
                stall_left--;
            end else if (mode == 1) begin
                DMA_not_ready = ($urandom_range(0, 3) == 0);
            end else begin
                DMA_not_ready = 1'b0;
            end
            pixel_valid_i = (mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
            pixel_i       = img[idx / w][idx % w];
            if (data_valid_o && !DMA_not_ready) got.push_back(pixel_grid_o);
            #1;
            checks++;
            if (pixel_ready_o !== !DMA_not_ready) begin
                failures++;
                $display("FAIL ready: pixel_ready_o=%b required %b (stall=%b)", pixel_ready_o, !DMA_not_ready, DMA_not_ready);
            end
            if (pixel_valid_i && pixel_ready_o) begin
                last_acc = cyc;
                idx++;
            end
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (idx != w*h) begin
            failures++;
            $display("FAIL frame_timeout: accepted=%0d required=%0d", idx, w*h);
        end
        if (mode == 2) begin
            checks++;
            if (!stalled_once || chk_left != 0) begin
                failures++;
                $display("FAIL stall_seen: stalled=%0d pending=%0d required stalled=1 pending=0", stalled_once, chk_left);
            end
        end
        pixel_valid_i = 1'b0;
        DMA_not_ready = 1'b0;
        for (int d = 0; d < 4; d++) begin
            if (frame_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (data_valid_o) got.push_back(pixel_grid_o);
            if (start_in_done && frame_done_o) begin
                line_width_i   = 6'd5;
                frame_height_i = 6'd3;
                start_i        = 1'b1;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            cyc++;
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_acc + 1) begin
            failures++;
            $display("FAIL frame_done: pulses=%0d at=%0d required pulses=1 at=%0d", done_cnt, done_cyc, last_acc + 1);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_after: busy_o=%b required 0", busy_o);
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL window_count: got=%0d required=%0d (W=%0d H=%0d)", got.size(), exp_q.size(), w, h);
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL window[%0d]: got=%h required=%h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic fill_seq();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                img[r][c] = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'(r*4 + c + 1);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                img[r][c] = 8'($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (pixel_grid_o !== '0 || data_valid_o !== 1'b0 || pixel_ready_o !== 1'b0 ||
            busy_o !== 1'b0 || frame_done_o !== 1'b0) begin
            failures++;
            $display("FAIL %s: grid=%h valid=%b ready=%b busy=%b done=%b required all 0",
                     tag, pixel_grid_o, data_valid_o, pixel_ready_o, busy_o, frame_done_o);
        end
    endtask

    task automatic test_reset();
        resetn_i = 1'b0; DMA_not_ready = 1'b0; start_i = 1'b0; pixel_valid_i = 1'b0;
        pixel_i = '0; line_width_i = 6'd4; frame_height_i = 6'd4;
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk_i);
        @(negedge clk_i);
        resetn_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_4x4();
        int e1[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        int e4[9] = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        fill_seq();
        run_frame(4, 4, 0, 1'b0);
        if (got.size() >= 4) begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (got[0][k*DR +: DR] !== 8'(e1[k]) || got[3][k*DR +: DR] !== 8'(e4[k])) begin
                    failures++;
                    $display("FAIL 4x4_const[%0d]: first=%0d fourth=%0d required %0d and %0d",
                             k, got[0][k*DR +: DR], got[3][k*DR +: DR], e1[k], e4[k]);
                end
            end
        end
    endtask

    task automatic test_stall();
        fill_seq();
        run_frame(4, 4, 2, 1'b0);
    endtask

    task automatic test_max_width();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                img[r][c] = 8'(r*32 + c);
        run_frame(32, 3, 0, 1'b0);
        checks++;
        if (got.size() != 30 || got[got.size()-1][2*DR +: DR] !== 8'd31 ||
            got[got.size()-1][5*DR +: DR] !== 8'd63 || got[got.size()-1][8*DR +: DR] !== 8'd95) begin
            failures++;
            $display("FAIL max_width_last: count=%0d required 30 with right column 31/63/95", got.size());
        end
    endtask

    task automatic test_reset_mid();
        fill_seq();
        @(negedge clk_i);
        line_width_i = 6'd4; frame_height_i = 6'd4; start_i = 1'b1; DMA_not_ready = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 11; k++) begin
            pixel_i = 8'(k + 1);
            pixel_valid_i = 1'b1;
            @(negedge clk_i);
        end
        pixel_valid_i = 1'b0;
        checks++;
        if (data_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: valid=%b busy=%b required 1 and 1", data_valid_o, busy_o);
        end
        #2;
        resetn_i = 1'b0;
        #1;
        check_idle_outputs("async_reset_mid");
        @(negedge clk_i);
        resetn_i = 1'b1;
        run_frame(4, 4, 0, 1'b0);
    endtask

    task automatic test_bad_geom();
        int bw[2] = '{2, 4};
        int bh[2] = '{3, 40};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            line_width_i = 6'(bw[i]); frame_height_i = 6'(bh[i]);
            DMA_not_ready = 1'b0; start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            checks++;
            if (busy_o !== 1'b0 || pixel_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bad_geom W=%0d H=%0d: busy=%b ready=%b required 0 and 0", bw[i], bh[i], busy_o, pixel_ready_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        fill_rand();
        run_frame(3, 3, 0, 1'b1);
        checks++;
        if (got.size() != 1) begin
            failures++;
            $display("FAIL b2b_first_count: got=%0d required 1", got.size());
        end
        fill_rand();
        run_frame(5, 3, 0, 1'b0);
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL b2b_second_count: got=%0d required 3", got.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 8)), 1, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_4x4();
        test_stall();
        test_max_width();
        test_reset_mid();
        test_bad_geom();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
